// File: rtl/wb_req_master.sv
// Single-outstanding Wishbone classic-cycle initiator: one command in, one bus cycle
// (with retry/backoff, error and timeout handling), one response out.
module wb_req_master #(
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    localparam int unsigned RTY_W = 4;
    localparam int unsigned TMO_W = 16;
    localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(RETRY_MAX);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_RTY = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [RTY_W-1:0]  rty_cnt_q, rty_cnt_d, rty_inc;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d, tmo_inc;

    assign rty_inc = rty_cnt_q + RTY_W'(1);
    assign tmo_inc = tmo_cnt_q + TMO_W'(1);

    // State register and registered outputs; reset drops cyc/stb asynchronously.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= '0;
            rty_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            rty_cnt_q    <= rty_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        rty_cnt_d    = rty_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    adr_d     = cmd_adr_i;
                    dat_d     = cmd_dat_i;
                    sel_d     = cmd_sel_i;
                    we_d      = cmd_we_i;
                    rsp_dat_d = '0;
                    rty_cnt_d = '0;
                    tmo_cnt_d = '0;
                    cyc_d     = 1'b1;
                    state_d   = BUS;
                end
            end
            BUS: begin
                // Termination priority is ack > err > rty.
                if (wbm_ack_i) begin
                    rsp_dat_d    = we_q ? 32'h0 : wbm_dat_i;
                    rsp_status_d = ST_OK;
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (wbm_err_i) begin
                    rsp_dat_d    = '0;
                    rsp_status_d = ST_ERR;
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (wbm_rty_i) begin
                    rty_cnt_d = rty_inc;
                    cyc_d     = 1'b0;
                    if (rty_inc < RTY_LIM) begin
                        state_d = BACKOFF;
                    end else begin
                        rsp_dat_d    = '0;
                        rsp_status_d = ST_RTY;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end
                end else if (tmo_inc == TMO_LIM) begin
                    tmo_cnt_d    = tmo_inc;
                    rsp_dat_d    = '0;
                    rsp_status_d = ST_TMO;
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            BACKOFF: begin
                tmo_cnt_d = '0;
                cyc_d     = 1'b1;
                state_d   = BUS;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_we_o     = we_q;
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = cyc_q;
    assign wbm_cti_o    = 3'b000;
    assign wbm_bte_o    = 2'b00;

endmodule

// File: tb/tb_wb_req_master.sv
// Directed bench for wb_req_master with RETRY_MAX=3, TIMEOUT=8.
module tb_wb_req_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel;
    logic        wbm_we, wbm_cyc, wbm_stb;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic        ack, err, rty;

    int errors = 0;
    int checks = 0;

    wb_req_master #(.RETRY_MAX(3), .TIMEOUT(8)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_adr_i    (cmd_adr),
        .cmd_dat_i    (cmd_dat),
        .cmd_sel_i    (cmd_sel),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_dat_o    (rsp_dat),
        .rsp_status_o (rsp_status),
        .wbm_adr_o    (wbm_adr),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_sel_o    (wbm_sel),
        .wbm_we_o     (wbm_we),
        .wbm_cyc_o    (wbm_cyc),
        .wbm_stb_o    (wbm_stb),
        .wbm_cti_o    (wbm_cti),
        .wbm_bte_o    (wbm_bte),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack_i    (ack),
        .wbm_err_i    (err),
        .wbm_rty_i    (rty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command, check it is taken, and land in the first stb cycle.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("cyc_after_accept", 32'(wbm_cyc), 32'd1);
        chk("adr_after_accept", wbm_adr, adr);
        chk("cmd_ready_in_bus", 32'(cmd_ready), 32'd0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_dat_i = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;
        #1;
        // Reset values
        chk("rst_cyc", 32'(wbm_cyc), 32'd0);
        chk("rst_stb", 32'(wbm_stb), 32'd0);
        chk("rst_we", 32'(wbm_we), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_adr", wbm_adr, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_sel", 32'(wbm_sel), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_status", 32'(rsp_status), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("cti", 32'(wbm_cti), 32'd0);
        chk("bte", 32'(wbm_bte), 32'd0);
        #13 rst_n = 1'b1;
        tick();

        // Terminations while idle are ignored
        ack = 1'b1; err = 1'b1; rty = 1'b1;
        tick();
        chk("idle_term_cyc", 32'(wbm_cyc), 32'd0);
        chk("idle_term_rsp_valid", 32'(rsp_valid), 32'd0);
        ack = 1'b0; err = 1'b0; rty = 1'b0;

        // Zero-wait read
        issue(1'b0, 32'h0000_1000, 32'h0, 4'hF);
        chk("rd0_rsp_valid_early", 32'(rsp_valid), 32'd0);
        ack = 1'b1; wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        chk("rd0_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd0_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
        chk("rd0_status", 32'(rsp_status), 32'd0);
        chk("rd0_cyc_one_cycle", 32'(wbm_cyc), 32'd0);
        handshake();

        // Write, ack after 3 wait cycles
        issue(1'b1, 32'h0000_1400, 32'h1234_5678, 4'hF);
        wbm_dat_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk("wr_cyc", 32'(wbm_cyc), 32'd1);
            chk("wr_stb", 32'(wbm_stb), 32'd1);
            chk("wr_dat", wbm_dat_o, 32'h1234_5678);
            chk("wr_sel", 32'(wbm_sel), 32'hF);
            chk("wr_we", 32'(wbm_we), 32'd1);
            chk("wr_rsp_valid_wait", 32'(rsp_valid), 32'd0);
            if (i == 3) ack = 1'b1;
            tick();
        end
        ack = 1'b0;
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_dat", rsp_dat, 32'd0);
        chk("wr_status", 32'(rsp_status), 32'd0);
        handshake();

        // rty, rty, then ack; rty held through the backoff cycles
        issue(1'b0, 32'h0000_2000, 32'h0, 4'h3);
        rty = 1'b1;
        tick();
        chk("rt1_backoff_cyc", 32'(wbm_cyc), 32'd0);
        tick();
        chk("rt1_reissue_cyc", 32'(wbm_cyc), 32'd1);
        chk("rt1_reissue_adr", wbm_adr, 32'h0000_2000);
        tick();
        chk("rt2_backoff_cyc", 32'(wbm_cyc), 32'd0);
        chk("rt2_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("rt2_reissue_cyc", 32'(wbm_cyc), 32'd1);
        rty = 1'b0; ack = 1'b1; wbm_dat_i = 32'hA5A5_0001;
        tick();
        ack = 1'b0;
        chk("rt_ok_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rt_ok_status", 32'(rsp_status), 32'd0);
        chk("rt_ok_rsp_dat", rsp_dat, 32'hA5A5_0001);
        handshake();

        // Retry exhausted after third rty
        issue(1'b0, 32'h0000_2004, 32'h0, 4'hF);
        rty = 1'b1;
        tick();
        chk("rx_b1_cyc", 32'(wbm_cyc), 32'd0);
        tick();
        chk("rx_a2_cyc", 32'(wbm_cyc), 32'd1);
        tick();
        chk("rx_b2_cyc", 32'(wbm_cyc), 32'd0);
        tick();
        chk("rx_a3_cyc", 32'(wbm_cyc), 32'd1);
        tick();
        chk("rx_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rx_status", 32'(rsp_status), 32'd3);
        chk("rx_rsp_dat", rsp_dat, 32'd0);
        chk("rx_cyc", 32'(wbm_cyc), 32'd0);
        tick();
        chk("rx_no_fourth_cyc", 32'(wbm_cyc), 32'd0);
        chk("rx_rsp_hold", 32'(rsp_valid), 32'd1);
        rty = 1'b0;
        handshake();

        // Timeout: cyc high exactly 8 cycles
        issue(1'b0, 32'h0000_3000, 32'h0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            chk("tmo_cyc_high", 32'(wbm_cyc), 32'd1);
            chk("tmo_rsp_valid_wait", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("tmo_cyc_low", 32'(wbm_cyc), 32'd0);
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo_status", 32'(rsp_status), 32'd2);
        chk("tmo_rsp_dat", rsp_dat, 32'd0);
        handshake();

        // ack+err+rty together is an ack
        issue(1'b0, 32'h0000_3004, 32'h0, 4'hF);
        ack = 1'b1; err = 1'b1; rty = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
        tick();
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        chk("all_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("all_status", 32'(rsp_status), 32'd0);
        chk("all_rsp_dat", rsp_dat, 32'h0BAD_F00D);
        handshake();

        // err on read, then response back-pressured with a new command waiting
        issue(1'b0, 32'h0000_3008, 32'h0, 4'hF);
        err = 1'b1; wbm_dat_i = 32'h5555_5555;
        tick();
        err = 1'b0;
        cmd_valid = 1'b1; cmd_adr = 32'h0000_9999;
        for (int i = 0; i < 5; i++) begin
            chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("err_status", 32'(rsp_status), 32'd1);
            chk("err_rsp_dat", rsp_dat, 32'd0);
            chk("err_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("err_cyc", 32'(wbm_cyc), 32'd0);
            chk("err_adr_hold", wbm_adr, 32'h0000_3008);
            tick();
        end
        cmd_valid = 1'b0;
        handshake();

        // Reset during a bus wait
        issue(1'b1, 32'h0000_5000, 32'hCAFE_0000, 4'hC);
        tick();
        chk("rstmid_cyc_before", 32'(wbm_cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_cyc_async", 32'(wbm_cyc), 32'd0);
        chk("rstmid_stb_async", 32'(wbm_stb), 32'd0);
        chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        #2 rst_n = 1'b1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rstmid_cyc_idle", 32'(wbm_cyc), 32'd0);
        chk("rstmid_cmd_ready_idle", 32'(cmd_ready), 32'd1);

        // Next command runs normally
        issue(1'b0, 32'h0000_4000, 32'h0, 4'hF);
        ack = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
        tick();
        ack = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_rsp_dat", rsp_dat, 32'hCAFE_F00D);
        chk("post_status", 32'(rsp_status), 32'd0);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
